// File: rtl/lcd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_pkg : shared states, HD44780 constants and helpers for the writer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_INIT_WR   = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_IDLE      = 3'd3,
        ST_SETUP     = 3'd4,
        ST_E_HIGH    = 3'd5,
        ST_GAP       = 3'd6,
        ST_EXEC_WAIT = 3'd7
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [3:0] LCD_INIT_NIB  = 4'h3;
    localparam logic [3:0] LCD_FUNC4_NIB = 4'h2;

    // Clear and home (plus the 0x03 home alias) differ only in bits [1:0].
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data >> 2) == ((LCD_CMD_CLEAR | LCD_CMD_HOME) >> 2));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_delay_counter : loadable down-counter with zero flag              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module lcd_delay_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RESET_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_timed_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_timed_writer : timed HD44780 byte writer with optional power-on   |
// | initialisation, 4- or 8-bit bus.                       Rev 1.0        |
// +-----------------------------------------------------------------------+
module lcd_timed_writer #(
    parameter int BUS_8BIT       = 0,
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int EXEC_CYC       = 2000,
    parameter int SLOW_EXEC_CYC  = 82000,
    parameter int INIT_EN        = 1,
    parameter int POWERUP_CYC    = 750000,
    parameter int INIT_W1_CYC    = 205000,
    parameter int INIT_W2_CYC    = 5000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [7:0]                          data_in,
    input  logic                                rs,
    input  logic                                send,
    output logic                                busy,
    output logic                                init_done,
    output logic                                lcd_rs,
    output logic                                lcd_rw,
    output logic                                lcd_e,
    output logic [((BUS_8BIT != 0) ? 8 : 4)-1:0] lcd_data
);
    import lcd_pkg::*;

    localparam int c_dw = (BUS_8BIT != 0) ? 8 : 4;
    localparam int c_max_delay = max_int(
        max_int(max_int(SETUP_CYC, E_PULSE_CYC), max_int(NIBBLE_GAP_CYC, EXEC_CYC)),
        max_int(max_int(SLOW_EXEC_CYC, POWERUP_CYC), max_int(INIT_W1_CYC, INIT_W2_CYC)));
    localparam int c_cw = $clog2(c_max_delay) + 1;

    localparam logic [c_cw-1:0] c_ld_setup = c_cw'(SETUP_CYC - 1);
    localparam logic [c_cw-1:0] c_ld_e     = c_cw'(E_PULSE_CYC - 1);
    localparam logic [c_cw-1:0] c_ld_gap   = c_cw'(NIBBLE_GAP_CYC - 1);
    localparam logic [c_cw-1:0] c_ld_exec  = c_cw'(EXEC_CYC - 1);
    localparam logic [c_cw-1:0] c_ld_slow  = c_cw'(SLOW_EXEC_CYC - 1);
    localparam logic [c_cw-1:0] c_ld_w1    = c_cw'(INIT_W1_CYC - 1);
    localparam logic [c_cw-1:0] c_ld_w2    = c_cw'(INIT_W2_CYC - 1);
    localparam logic [c_cw-1:0] c_ld_pwr   = (INIT_EN != 0) ? c_cw'(POWERUP_CYC - 1) : '0;
    localparam logic [1:0]      c_last_step = (BUS_8BIT != 0) ? 2'd2 : 2'd3;

    lcd_state_t        r_state;
    logic              r_busy;
    logic              r_init_done;
    logic              r_e;
    logic              r_rs;
    logic [c_dw-1:0]   r_data;
    logic [c_dw-1:0]   r_low;
    logic              r_slow;
    logic              r_second;
    logic [1:0]        r_init_step;
    logic              w_zero;
    logic              w_load;
    logic [c_cw-1:0]   w_load_val;
    logic [c_dw-1:0]   w_first;
    logic [c_dw-1:0]   w_second;
    logic [c_dw-1:0]   w_init_val;

    if (BUS_8BIT != 0) begin : g_bus8
        assign w_first    = data_in;
        assign w_second   = data_in;
        assign w_init_val = {LCD_INIT_NIB, 4'h0};
    end else begin : g_bus4
        assign w_first    = data_in[7:4];
        assign w_second   = data_in[3:0];
        assign w_init_val = (r_init_step == 2'd3) ? LCD_FUNC4_NIB : LCD_INIT_NIB;
    end

    lcd_delay_counter #(
        .WIDTH     (c_cw),
        .RESET_VAL (c_ld_pwr)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    // Length of the phase being entered, loaded on the same edge as the state change.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_INIT_WR: begin
                w_load     = 1'b1;
                w_load_val = c_ld_setup;
            end
            ST_IDLE: begin
                if (send) begin
                    w_load     = 1'b1;
                    w_load_val = c_ld_setup;
                end
            end
            ST_SETUP: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_ld_e;
                end
            end
            ST_E_HIGH: begin
                if (w_zero) begin
                    w_load = 1'b1;
                    if (!r_init_done) begin
                        case (r_init_step)
                            2'd0:    w_load_val = c_ld_w1;
                            2'd1:    w_load_val = c_ld_w2;
                            default: w_load_val = c_ld_exec;
                        endcase
                    end else if (!r_second) begin
                        w_load_val = c_ld_gap;
                    end else begin
                        w_load_val = r_slow ? c_ld_slow : c_ld_exec;
                    end
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_ld_setup;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_PWR_WAIT;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= '0;
            r_low       <= '0;
            r_slow      <= 1'b0;
            r_second    <= 1'b0;
            r_init_step <= 2'd0;
        end else begin
            case (r_state)
                ST_PWR_WAIT: begin
                    if (INIT_EN == 0) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                    end else if (w_zero) begin
                        r_state <= ST_INIT_WR;
                    end
                end
                ST_INIT_WR: begin
                    r_rs     <= 1'b0;
                    r_data   <= w_init_val;
                    r_second <= 1'b1;
                    r_state  <= ST_SETUP;
                end
                ST_INIT_WAIT: begin
                    if (w_zero) begin
                        if (r_init_step == c_last_step) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_init_done <= 1'b1;
                        end else begin
                            r_init_step <= r_init_step + 2'd1;
                            r_state     <= ST_INIT_WR;
                        end
                    end
                end
                ST_IDLE: begin
                    if (send) begin
                        r_busy   <= 1'b1;
                        r_rs     <= rs;
                        r_data   <= w_first;
                        r_low    <= w_second;
                        r_slow   <= is_slow_cmd(rs, data_in);
                        r_second <= (BUS_8BIT != 0);
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_zero) begin
                        r_e     <= 1'b1;
                        r_state <= ST_E_HIGH;
                    end
                end
                ST_E_HIGH: begin
                    if (w_zero) begin
                        r_e <= 1'b0;
                        if (!r_init_done) begin
                            r_state <= ST_INIT_WAIT;
                        end else if (!r_second) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_EXEC_WAIT;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_zero) begin
                        r_data   <= r_low;
                        r_second <= 1'b1;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_EXEC_WAIT: begin
                    if (w_zero) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_PWR_WAIT;
            endcase
        end
    end

    assign busy      = r_busy;
    assign init_done = r_init_done;
    assign lcd_rs    = r_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = r_e;
    assign lcd_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timed_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_lcd_timed_writer : self-checking bench for lcd_timed_writer        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lcd_timed_writer;

    localparam int S = 1, E = 2, G = 3, X = 5, XS = 9, P = 10, W1 = 6, W2 = 4;

    typedef struct {
        bit         bus8;
        logic [7:0] b;
        logic       r;
        int         busy_edge;
        int         rises;
        logic [7:0] d1;
        logic [7:0] d2;
    } vec_t;

    typedef struct packed {
        logic       e;
        logic       busy;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, rst8, rsti;
    logic [7:0] din4, din8, dini;
    logic       rs4, rs8, rsi, send4, send8, sendi;
    logic       busy4, busy8, busyi, idone4, idone8, idonei;
    logic       lrs4, lrs8, lrsi, rw4, rw8, rwi, e4, e8, ei;
    logic [3:0] ld4, ldi;
    logic [7:0] ld8;

    int checks = 0;
    int failures = 0;

    lcd_timed_writer #(.BUS_8BIT(0), .SETUP_CYC(S), .E_PULSE_CYC(E), .NIBBLE_GAP_CYC(G),
        .EXEC_CYC(X), .SLOW_EXEC_CYC(XS), .INIT_EN(0), .POWERUP_CYC(P),
        .INIT_W1_CYC(W1), .INIT_W2_CYC(W2)) dut4 (
        .clk(clk), .reset(rst4), .data_in(din4), .rs(rs4), .send(send4), .busy(busy4),
        .init_done(idone4), .lcd_rs(lrs4), .lcd_rw(rw4), .lcd_e(e4), .lcd_data(ld4));

    lcd_timed_writer #(.BUS_8BIT(1), .SETUP_CYC(S), .E_PULSE_CYC(E), .NIBBLE_GAP_CYC(G),
        .EXEC_CYC(X), .SLOW_EXEC_CYC(XS), .INIT_EN(0), .POWERUP_CYC(P),
        .INIT_W1_CYC(W1), .INIT_W2_CYC(W2)) dut8 (
        .clk(clk), .reset(rst8), .data_in(din8), .rs(rs8), .send(send8), .busy(busy8),
        .init_done(idone8), .lcd_rs(lrs8), .lcd_rw(rw8), .lcd_e(e8), .lcd_data(ld8));

    lcd_timed_writer #(.BUS_8BIT(0), .SETUP_CYC(S), .E_PULSE_CYC(E), .NIBBLE_GAP_CYC(G),
        .EXEC_CYC(X), .SLOW_EXEC_CYC(XS), .INIT_EN(1), .POWERUP_CYC(P),
        .INIT_W1_CYC(W1), .INIT_W2_CYC(W2)) duti (
        .clk(clk), .reset(rsti), .data_in(dini), .rs(rsi), .send(sendi), .busy(busyi),
        .init_done(idonei), .lcd_rs(lrsi), .lcd_rw(rwi), .lcd_e(ei), .lcd_data(ldi));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: outputs d edges after the send edge, from the published phase timing.
    function automatic exp_t model(input bit bus8, input int d, input logic [7:0] b, input logic r);
        exp_t x;
        int   ex;
        ex = (!r && b < 8'd4) ? XS : X;
        if (bus8) begin
            x.e    = (d >= S) && (d < S + E);
            x.data = b;
            x.busy = d < S + E + ex;
        end else begin
            x.e    = ((d >= S) && (d < S + E)) || ((d >= 2*S + E + G) && (d < 2*S + 2*E + G));
            x.data = (d < S + E + G) ? {4'h0, b[7:4]} : {4'h0, b[3:0]};
            x.busy = d < 2*S + 2*E + G + ex;
        end
        return x;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int         busy_fall;
        int         nr;
        int         r_edge[2];
        logic [7:0] r_data[2];
        logic       prev_e, cur_e, cur_b, cur_rs;
        logic [7:0] cur_d;
        busy_fall = -1;
        nr = 0;
        prev_e = 1'b0;
        r_edge = '{-1, -1};
        r_data = '{8'h0, 8'h0};
        if (v.bus8) begin din8 = v.b; rs8 = v.r; send8 = 1'b1; end
        else        begin din4 = v.b; rs4 = v.r; send4 = 1'b1; end
        for (int k = 0; k < 40; k++) begin
            step();
            send4 = 1'b0;
            send8 = 1'b0;
            cur_e  = v.bus8 ? e8 : e4;
            cur_b  = v.bus8 ? busy8 : busy4;
            cur_rs = v.bus8 ? lrs8 : lrs4;
            cur_d  = v.bus8 ? ld8 : {4'h0, ld4};
            if (k == 0) begin
                chk($sformatf("v%0d_first_data", idx), cur_d, v.bus8 ? v.b : {4'h0, v.b[7:4]});
                chk($sformatf("v%0d_busy_after_send", idx), cur_b, 1);
                chk($sformatf("v%0d_lcd_rs", idx), cur_rs, v.r);
            end
            if (cur_e && !prev_e) begin
                if (nr < 2) begin r_edge[nr] = k; r_data[nr] = cur_d; end
                nr++;
            end
            prev_e = cur_e;
            if (!cur_b && busy_fall < 0) busy_fall = k;
        end
        chk($sformatf("v%0d_busy_fall_edge", idx), busy_fall, v.busy_edge);
        chk($sformatf("v%0d_e_pulses", idx), nr, v.rises);
        chk($sformatf("v%0d_rise1_edge", idx), r_edge[0], S);
        chk($sformatf("v%0d_rise1_data", idx), r_data[0], v.d1);
        if (v.rises == 2) begin
            chk($sformatf("v%0d_rise2_edge", idx), r_edge[1], 2*S + E + G);
            chk($sformatf("v%0d_rise2_data", idx), r_data[1], v.d2);
        end
    endtask

    vec_t       vecs[9];
    int         t0[2], fall[2];
    logic [7:0] mb[2];
    logic       mr[2];
    exp_t       x;
    logic       s, r, prev;
    logic [7:0] b;
    int         rise_k[$];
    logic [3:0] rise_d[$];
    logic       rise_rs[$];
    int         exp_rise[4];
    logic [3:0] init_vals[4];
    int         waits[4];
    int         ts, exp_end, lo_cnt, lo_edge, found;

    initial begin
        vecs[0] = '{1'b0, 8'h48, 1'b1, 14, 2, 8'h04, 8'h08};
        vecs[1] = '{1'b0, 8'h01, 1'b0, 18, 2, 8'h00, 8'h01};
        vecs[2] = '{1'b0, 8'h80, 1'b0, 14, 2, 8'h08, 8'h00};
        vecs[3] = '{1'b0, 8'h03, 1'b0, 18, 2, 8'h00, 8'h03};
        vecs[4] = '{1'b0, 8'h02, 1'b1, 14, 2, 8'h00, 8'h02};
        vecs[5] = '{1'b0, 8'h04, 1'b0, 14, 2, 8'h00, 8'h04};
        vecs[6] = '{1'b1, 8'hA5, 1'b1,  8, 1, 8'hA5, 8'h00};
        vecs[7] = '{1'b1, 8'h01, 1'b0, 12, 1, 8'h01, 8'h00};
        vecs[8] = '{1'b1, 8'h30, 1'b0,  8, 1, 8'h30, 8'h00};

        rst4 = 1'b1; rst8 = 1'b1; rsti = 1'b1;
        din4 = 8'h0; din8 = 8'h0; dini = 8'h0;
        rs4 = 1'b0; rs8 = 1'b0; rsi = 1'b0;
        send4 = 1'b0; send8 = 1'b0; sendi = 1'b0;
        step();
        step();
        chk("rst_busy", {busy4, busy8, busyi}, 3'b111);
        chk("rst_init_done", {idone4, idone8, idonei}, 3'b000);
        chk("rst_lcd_e", {e4, e8, ei}, 3'b000);
        chk("rst_lcd_rs", {lrs4, lrs8, lrsi}, 3'b000);
        chk("rst_lcd_rw", {rw4, rw8, rwi}, 3'b000);
        chk("rst_lcd_data", {ld4, ld8, ldi}, 16'h0000);

        rst4 = 1'b0; rst8 = 1'b0;
        step();
        chk("noinit_idle_busy", {busy4, busy8}, 2'b00);
        chk("noinit_init_done", {idone4, idone8}, 2'b11);
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Randomized traffic on both no-init DUTs against the timing model.
        rst4 = 1'b1; rst8 = 1'b1;
        step();
        rst4 = 1'b0; rst8 = 1'b0;
        for (int k = 0; k < 2; k++) begin t0[k] = -1; fall[k] = 1; mb[k] = 8'h0; mr[k] = 1'b0; end
        for (int n = 1; n <= 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                s = ($urandom_range(0, 2) == 0);
                b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                r = 1'($urandom_range(0, 1));
                if (k == 0) begin send4 = s; din4 = b; rs4 = r; end
                else        begin send8 = s; din8 = b; rs8 = r; end
                if (s && n > fall[k]) begin
                    t0[k] = n; mb[k] = b; mr[k] = r;
                    x = model(k == 1, 0, b, r);
                    fall[k] = n;
                    for (int d = 0; d < 64 && model(k == 1, d, b, r).busy; d++) fall[k] = n + d + 1;
                end
            end
            step();
            for (int k = 0; k < 2; k++) begin
                if (t0[k] < 0) begin
                    x.e = 1'b0; x.data = 8'h0; x.busy = (n < fall[k]);
                end else begin
                    x = model(k == 1, n - t0[k], mb[k], mr[k]);
                end
                chk($sformatf("rand%0d_n%0d_e", k, n), (k == 1) ? e8 : e4, x.e);
                chk($sformatf("rand%0d_n%0d_busy", k, n), (k == 1) ? busy8 : busy4, x.busy);
                chk($sformatf("rand%0d_n%0d_data", k, n), (k == 1) ? ld8 : {4'h0, ld4}, x.data);
                chk($sformatf("rand%0d_n%0d_rs", k, n), (k == 1) ? lrs8 : lrs4, (t0[k] < 0) ? 1'b0 : mr[k]);
            end
        end
        send4 = 1'b0; send8 = 1'b0;

        // send held high across two transfers on the 4-bit bus.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin step(); if (!busy4) found = 1; end
        chk("b2b_idle_reached", found, 1);
        din4 = 8'h48; rs4 = 1'b1; send4 = 1'b1;
        step();
        din4 = 8'h3C;
        rise_k.delete(); rise_d.delete();
        prev = e4; lo_cnt = 0; lo_edge = -1;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k == 15) send4 = 1'b0;
            if (e4 && !prev) begin rise_k.push_back(k); rise_d.push_back(ld4); end
            prev = e4;
            if (k <= 28 && !busy4) begin lo_cnt++; lo_edge = k; end
        end
        chk("b2b_busy_low_cycles", lo_cnt, 1);
        chk("b2b_busy_low_edge", lo_edge, 14);
        chk("b2b_e_pulses", rise_k.size(), 4);
        if (rise_k.size() == 4) begin
            chk("b2b_rise3_edge", rise_k[2], 16);
            chk("b2b_rise3_data", rise_d[2], 4'h3);
            chk("b2b_rise4_data", rise_d[3], 4'hC);
        end
        chk("b2b_final_busy", busy4, 0);

        // Power-on initialisation: pulse times derived from the wait chain.
        init_vals = '{4'h3, 4'h3, 4'h3, 4'h2};
        waits = '{W1, W2, X, X};
        ts = P + 1;
        for (int i = 0; i < 4; i++) begin
            exp_rise[i] = ts + S;
            ts = ts + S + E + waits[i] + 1;
        end
        exp_end = ts - 1;
        rsti = 1'b1;
        step();
        rsti = 1'b0;
        rise_k.delete(); rise_d.delete(); rise_rs.delete();
        prev = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            sendi = (k <= 40);
            dini = 8'($urandom);
            rsi = 1'($urandom_range(0, 1));
            step();
            if (ei && !prev) begin rise_k.push_back(k); rise_d.push_back(ldi); rise_rs.push_back(lrsi); end
            prev = ei;
            chk($sformatf("init_k%0d_busy", k), busyi, (k < exp_end));
            chk($sformatf("init_k%0d_init_done", k), idonei, (k >= exp_end));
            chk($sformatf("init_k%0d_rs_rw", k), {lrsi, rwi}, 2'b00);
        end
        sendi = 1'b0;
        chk("init_e_pulses", rise_k.size(), 4);
        for (int i = 0; i < 4 && i < rise_k.size(); i++) begin
            chk($sformatf("init_rise%0d_edge", i), rise_k[i], exp_rise[i]);
            chk($sformatf("init_rise%0d_data", i), rise_d[i], init_vals[i]);
            chk($sformatf("init_rise%0d_rs", i), rise_rs[i], 0);
        end

        // Reset while E is high, then init must run again from the top.
        dini = 8'h5A; rsi = 1'b1; sendi = 1'b1;
        step();
        sendi = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (ei) found = 1;
            else step();
        end
        chk("midE_e_seen", found, 1);
        rsti = 1'b1;
        #1;
        chk("midE_reset_outputs", {ei, busyi, idonei, lrsi}, 4'b0100);
        chk("midE_reset_data", ldi, 4'h0);
        step();
        rsti = 1'b0;
        found = -1;
        for (int k = 1; k <= 40 && found < 0; k++) begin
            step();
            if (ei) begin
                found = k;
                chk("reinit_rise_data", ldi, 4'h3);
            end
        end
        chk("reinit_first_rise_edge", found, P + 1 + S);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_timed_writer.md
# lcd_timed_writer

Parametrised HD44780 write engine for the health-monitor display path; successor to the bare nibble sender. Takes one byte per `send`, drives it onto a 4- or 8-bit LCD bus with programmable setup, E-pulse, inter-nibble and execution delays, and selects a long wait for clear/home commands. Optionally runs the HD44780 power-on initialisation itself before accepting traffic. Sits between the display-content sequencer and the LCD pins.

## Interface
- BUS_8BIT, 0: 0 drives a 4-bit bus (high nibble first); 1 drives an 8-bit bus (single transfer).
- SETUP_CYC, 2: cycles RS/data are stable before E rises (≥1).
- E_PULSE_CYC, 12: cycles E is high (≥1).
- NIBBLE_GAP_CYC, 50: cycles E is low between the two nibbles (≥1, 4-bit only).
- EXEC_CYC, 2000: wait after the last E fall for normal commands and data.
- SLOW_EXEC_CYC, 82000: wait after clear/home.
- INIT_EN, 1: run the power-on sequence after reset.
- POWERUP_CYC, 750000: wait from reset release to the first init write.
- INIT_W1_CYC, 205000 / INIT_W2_CYC, 5000: waits after init writes 1 and 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  byte to write.
- rs  in  1  0 = command, 1 = data.
- send  in  1  single-cycle request, sampled only when busy=0.
- busy  out  1  engine occupied (init or transfer).
- init_done  out  1  init sequence complete; stays high until reset.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  constant 0.
- lcd_e  out  1  LCD enable.
- lcd_data  out  DW  DW = BUS_8BIT ? 8 : 4.

## Operation
- Reset values: busy=1, init_done=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0. A reset mid-transfer drops E at once, discards the byte, and restarts init.
- States: PWR_WAIT, INIT_WR, INIT_WAIT, IDLE, SETUP, E_HIGH, GAP, EXEC_WAIT.
- INIT_EN=1: PWR_WAIT(POWERUP_CYC) → write 0x3 → wait INIT_W1_CYC → write 0x3 → wait INIT_W2_CYC → write 0x3 → wait EXEC_CYC → (4-bit only) write 0x2 → wait EXEC_CYC → IDLE.
  - Init writes are single transfers with rs=0, each using SETUP and E_HIGH.
  - On an 8-bit bus the init value is 0x30.
- INIT_EN=0: first edge after reset release → IDLE.
- On entry to IDLE: init_done=1, busy=0.
- IDLE with send=1: latch data_in and rs, busy=1, drive lcd_rs and the first nibble (or full byte), go to SETUP.
- Slow command: rs=0 and data_in[7:2]==0 (clear 0x01, home 0x02/0x03). EXEC_WAIT uses SLOW_EXEC_CYC for slow commands, otherwise EXEC_CYC.
- lcd_rs/lcd_data change only on the edge that starts SETUP, never while E=1. They hold their last value during waits and in IDLE.
- send while busy=1 is ignored (no queue).

## Timing
- Single delay counter, width $clog2 of the largest delay parameter plus 1. Load N−1 and advance on zero, so each phase lasts exactly N cycles.
- send sampled at edge 0 → busy=1, lcd_data=high nibble after edge 0. E rises at edge S and falls at edge S+E.
- 4-bit: low nibble driven at edge S+E+G. E rises at edge 2S+E+G and falls at edge 2S+2E+G.
- busy falls at edge 2S+2E+G+X, where X is the exec wait. 8-bit: S+E+X.
- A new send is accepted on the cycle busy is first low: zero bubble.

## Structure
- Package lcd_pkg: state enum; constants LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02, LCD_INIT_NIB=4'h3, LCD_FUNC4_NIB=4'h2; function is_slow_cmd(rs, byte).
- Sub-module lcd_delay_counter: loadable down-counter with a zero flag, shared by every wait phase.

## Test plan
Bench parameters: S=1, E=2, G=3, X=5, slow=9.
- INIT_EN=0, BUS_8BIT=0; send 0x48 with rs=1 → lcd_data 0x4, then 0x8. E high at edges 1–2 and 7–8. busy low at edge 14.
- Same bench; send command 0x01 → busy low at edge 18. Command 0x80 → busy low at edge 14.
- BUS_8BIT=1; send 0xA5 → one E pulse with lcd_data=0xA5. busy low at edge 8.
- INIT_EN=1, POWERUP=10, W1=6, W2=4 → E pulses carry 0x3, 0x3, 0x3, 0x2 with the programmed gaps. init_done and busy=0 at the end. send during init is ignored.
- Reset asserted while E=1 → lcd_e=0 and busy=1 immediately. Init restarts after release.
- send held high across two back-to-back transfers → exactly two writes, the second starting on the first cycle busy is low.
